// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - iterative restoring divider sequencer/datapath for exe1
// Handles div.w/div.wu/mod.w/mod.wu; stalls the pipeline while a divide is in flight.
module div_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             flush,
   input  logic             en_in,
   input  logic             op_signed,
   input  logic             op_mod,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic [4:0]       rd_in,
   output logic             stall_because_div,
   output logic [WIDTH-1:0] result,
   output logic             result_valid,
   output logic [4:0]       rd_out
);

   typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

   localparam logic [5:0] LAST = 6'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, r_q;
   logic [5:0]       cnt_q;
   logic             sgn_q, mod_q, neg_q, neg_r;
   logic [4:0]       rd_q;

   logic [WIDTH:0]   shifted, diff;
   logic             ge;
   logic [WIDTH-1:0] r_next, q_next, a_abs, b_abs, q_fix, r_fix;

   // a_q holds the dividend, then collects quotient bits from the LSB as it shifts out.
   always_comb begin
      shifted = {r_q, a_q[WIDTH-1]};
      diff    = shifted - {1'b0, b_q};
      ge      = !diff[WIDTH];
      r_next  = ge ? diff[WIDTH-1:0] : {r_q[WIDTH-2:0], a_q[WIDTH-1]};
      q_next  = {a_q[WIDTH-2:0], ge};
      a_abs   = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
      b_abs   = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
      q_fix   = neg_q ? -a_q : a_q;
      r_fix   = neg_r ? -r_q : r_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d           = state_q;
      stall_because_div = 1'b0;
      result_valid      = 1'b0;
      case (state_q)
         IDLE: begin
            stall_because_div = en_in;
            if (en_in) state_d = PREP;
         end
         PREP: begin
            stall_because_div = 1'b1;
            state_d           = (b_q == '0) ? DONE : CALC;
         end
         CALC: begin
            stall_because_div = 1'b1;
            if (cnt_q == LAST) state_d = FIX;
         end
         FIX: begin
            stall_because_div = 1'b1;
            state_d           = DONE;
         end
         DONE: begin
            result_valid = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (flush) begin
         state_d           = IDLE;
         stall_because_div = 1'b0;
         result_valid      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         a_q    <= '0;
         b_q    <= '0;
         r_q    <= '0;
         cnt_q  <= '0;
         sgn_q  <= 1'b0;
         mod_q  <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         rd_q   <= '0;
         result <= '0;
         rd_out <= '0;
      end else if (!flush) begin
         case (state_q)
            IDLE: begin
               if (en_in) begin
                  a_q   <= src_a;
                  b_q   <= src_b;
                  sgn_q <= op_signed;
                  mod_q <= op_mod;
                  rd_q  <= rd_in;
               end
            end
            PREP: begin
               r_q   <= '0;
               cnt_q <= '0;
               neg_q <= sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
               neg_r <= sgn_q && a_q[WIDTH-1];
               if (b_q == '0) begin
                  // Divide by zero: all-ones quotient, remainder is the untouched dividend.
                  result <= mod_q ? a_q : '1;
                  rd_out <= rd_q;
               end else begin
                  a_q <= a_abs;
                  b_q <= b_abs;
               end
            end
            CALC: begin
               a_q   <= q_next;
               r_q   <= r_next;
               cnt_q <= cnt_q + 6'd1;
            end
            FIX: begin
               result <= mod_q ? r_fix : q_fix;
               rd_out <= rd_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - self-checking bench for div_ctrl
// Vector table plus flush/reset/back-to-back sequences, results checked via scoreboard queue.
module tb_div_ctrl;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        flush = 1'b0;
   logic        en_in = 1'b0;
   logic        op_signed = 1'b0;
   logic        op_mod = 1'b0;
   logic [31:0] src_a = '0;
   logic [31:0] src_b = '0;
   logic [4:0]  rd_in = '0;
   logic        stall_because_div;
   logic [31:0] result;
   logic        result_valid;
   logic [4:0]  rd_out;

   div_ctrl #(.WIDTH(32)) dut (
      .clk(clk), .rstn(rstn), .flush(flush), .en_in(en_in),
      .op_signed(op_signed), .op_mod(op_mod), .src_a(src_a), .src_b(src_b),
      .rd_in(rd_in), .stall_because_div(stall_because_div), .result(result),
      .result_valid(result_valid), .rd_out(rd_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        s;
      logic        m;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   runs = 0;
   int   n_valid = 0;

   always @(posedge clk) if (result_valid) n_valid++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic s, input logic m,
                                         input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q, r;
      if (b == 32'd0) begin
         q = '1;
         r = a;
      end else if (s) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = '0;
         end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
         end
      end else begin
         q = a / b;
         r = a % b;
      end
      return m ? r : q;
   endfunction

   task automatic run_div(input logic s, input logic m, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_lat, input bit hold);
      exp_t e, got_e;
      int   lat;
      bit   got, stall_ok;
      e.res = exp;
      e.rd  = rd;
      sb.push_back(e);
      runs++;
      @(negedge clk);
      en_in = 1'b1; op_signed = s; op_mod = m; src_a = a; src_b = b; rd_in = rd;
      #1 chk("stall_c0", 32'(stall_because_div), 32'd1);
      lat = 0; got = 1'b0; stall_ok = 1'b1;
      while (!got && lat < 100) begin
         @(posedge clk); #1;
         if (!hold) en_in = 1'b0;
         lat++;
         if (result_valid) begin
            got = 1'b1;
            if (sb.size() > 0) begin
               got_e = sb.pop_front();
               chk("result", result, got_e.res);
               chk("rd_out", 32'(rd_out), 32'(got_e.rd));
            end
            chk("latency", 32'(lat), 32'(exp_lat));
            chk("stall_done", 32'(stall_because_div), 32'd0);
         end else if (!stall_because_div) begin
            stall_ok = 1'b0;
         end
      end
      if (!got && sb.size() > 0) void'(sb.pop_front());
      chk("no_timeout", 32'(got), 32'd1);
      chk("stall_during", 32'(stall_ok), 32'd1);
      @(posedge clk); #1;
      en_in = 1'b0;
      #1 chk("valid_after", 32'(result_valid), 32'd0);
      chk("stall_after", 32'(stall_because_div), 32'd0);
   endtask

   vec_t vecs[12];

   initial begin
      vecs[0]  = '{1'b0, 1'b0, 32'd100,        32'd7,          5'd5,  32'd14,         35};
      vecs[1]  = '{1'b1, 1'b1, 32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFF,  35};
      vecs[2]  = '{1'b1, 1'b0, 32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFD,  35};
      vecs[3]  = '{1'b0, 1'b0, 32'h0000_1234,  32'd0,          5'd6,  32'hFFFF_FFFF,  2};
      vecs[4]  = '{1'b0, 1'b1, 32'h0000_1234,  32'd0,          5'd7,  32'h0000_1234,  2};
      vecs[5]  = '{1'b1, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  5'd8,  32'h8000_0000,  35};
      vecs[6]  = '{1'b1, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  5'd9,  32'h0000_0000,  35};
      vecs[7]  = '{1'b0, 1'b0, 32'hFFFF_FFFF,  32'd1,          5'd10, 32'hFFFF_FFFF,  35};
      vecs[8]  = '{1'b0, 1'b1, 32'hFFFF_FFFF,  32'h10,         5'd11, 32'h0000_000F,  35};
      vecs[9]  = '{1'b1, 1'b1, 32'd7,          32'hFFFF_FFFE,  5'd12, 32'd1,          35};
      vecs[10] = '{1'b1, 1'b0, 32'd7,          32'hFFFF_FFFE,  5'd13, 32'hFFFF_FFFD,  35};
      vecs[11] = '{1'b1, 1'b1, 32'hFFFF_FFF0,  32'd0,          5'd31, 32'hFFFF_FFF0,  2};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_stall", 32'(stall_because_div), 32'd0);
      chk("rst_valid", 32'(result_valid), 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_rd_out", 32'(rd_out), 32'd0);
      @(posedge clk); #1 rstn = 1'b1;

      for (int i = 0; i < 12; i++)
         run_div(vecs[i].s, vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].rd,
                 vecs[i].exp, vecs[i].lat, 1'b0);

      for (int i = 0; i < 6; i++) begin
         logic        s, m;
         logic [31:0] a, b;
         s = 1'($urandom_range(0, 1));
         m = 1'($urandom_range(0, 1));
         a = $urandom;
         b = $urandom >> $urandom_range(0, 31);
         run_div(s, m, a, b, 5'(i + 1), model(s, m, a, b), (b == 32'd0) ? 2 : 35, 1'b0);
      end

      // en_in still high in DONE belongs to the retiring op; must not restart.
      run_div(1'b0, 1'b0, 32'd1000, 32'd10, 5'd2, 32'd100, 35, 1'b1);

      // en_in together with flush in IDLE is ignored.
      @(negedge clk);
      en_in = 1'b1; flush = 1'b1; src_a = 32'd50; src_b = 32'd5;
      #1 chk("flush_idle_stall", 32'(stall_because_div), 32'd0);
      @(posedge clk); #1;
      en_in = 1'b0; flush = 1'b0;
      #1 chk("flush_idle_stays", 32'(stall_because_div), 32'd0);

      // Flush at c10 kills the divide; a new one starts at c11.
      @(negedge clk);
      en_in = 1'b1; op_signed = 1'b0; op_mod = 1'b0; src_a = 32'd999; src_b = 32'd3; rd_in = 5'd17;
      repeat (10) begin
         @(posedge clk); #1 en_in = 1'b0;
      end
      flush = 1'b1;
      #1 chk("flush_stall", 32'(stall_because_div), 32'd0);
      chk("flush_valid", 32'(result_valid), 32'd0);
      @(posedge clk); #1 flush = 1'b0;
      #1 chk("post_flush_stall", 32'(stall_because_div), 32'd0);
      run_div(1'b1, 1'b1, 32'hFFFF_FF9C, 32'd7, 5'd18, 32'hFFFF_FFFE, 35, 1'b0);

      // Reset pulsed at c20; outputs return to reset values immediately.
      @(negedge clk);
      en_in = 1'b1; op_signed = 1'b0; op_mod = 1'b0; src_a = 32'd77; src_b = 32'd7; rd_in = 5'd20;
      repeat (20) begin
         @(posedge clk); #1 en_in = 1'b0;
      end
      rstn = 1'b0;
      #1 chk("rst_mid_stall", 32'(stall_because_div), 32'd0);
      chk("rst_mid_valid", 32'(result_valid), 32'd0);
      chk("rst_mid_result", result, 32'd0);
      chk("rst_mid_rd_out", 32'(rd_out), 32'd0);
      @(posedge clk); #1 rstn = 1'b1;
      run_div(1'b0, 1'b0, 32'd77, 32'd7, 5'd21, 32'd11, 35, 1'b0);

      repeat (5) @(posedge clk);
      #1 chk("valid_pulses", 32'(n_valid), 32'(runs));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencer and datapath for the iterative 32-bit integer divider in exe1; executes div.w/div.wu/mod.w/mod.wu issued on eu0.
- Drives stall_because_div into the hazard unit, which holds the pipeline while the divide is in flight.
- Presents the quotient or remainder for exactly one cycle when the stall is released.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rstn  input  1  asynchronous active-low reset.
- flush  input  1  pipeline flush (branch mispredict/exception); kills any in-flight divide.
- en_in  input  1  divide uop valid in exe1 this cycle.
- op_signed  input  1  1 = signed (div.w/mod.w), 0 = unsigned.
- op_mod  input  1  1 = return remainder, 0 = return quotient.
- src_a  input  WIDTH  dividend.
- src_b  input  WIDTH  divisor.
- rd_in  input  5  destination register.
- stall_because_div  output  1  hold pipeline (combinational).
- result  output  WIDTH  quotient or remainder.
- result_valid  output  1  result usable this cycle.
- rd_out  output  5  destination for result.

Behaviour:
- States: IDLE, PREP, CALC, FIX, DONE. Reset: IDLE, all registers 0, result_valid 0, result 0, rd_out 0, stall 0.
- stall_because_div = !flush && ((IDLE && en_in) || PREP || CALC || FIX). It is low in DONE.
- IDLE: if en_in && !flush, latch src_a, src_b, op_signed, op_mod, rd_in, then go to PREP.
- PREP:
  - If signed, take the absolute values of both operands as WIDTH-bit unsigned; abs(0x80000000) = 0x80000000.
  - Record neg_q = sign(a) XOR sign(b) and neg_r = sign(a); both are 0 when unsigned.
  - Clear the remainder register and the 6-bit counter.
  - If divisor == 0, go to DONE with quotient = all ones and remainder = original src_a. Otherwise go to CALC.
- CALC: one restoring shift-subtract step per cycle, MSB first, for WIDTH cycles (counter 0..WIDTH-1). Leave to FIX when counter == WIDTH-1.
- FIX:
  - Quotient = neg_q ? -q : q, in two's complement, WIDTH bits, wrap.
  - Remainder = neg_r ? -r : r.
  - Select the result by op_mod. Go to DONE.
- DONE: result_valid = 1; result and rd_out stable. Next state is always IDLE. en_in in DONE belongs to the retiring instruction and is ignored.
- Latency (en_in first seen in IDLE = cycle 0): PREP c1, CALC c2..c33, FIX c34, DONE c35. Stall is high c0..c34. Divide-by-zero reaches DONE at c2.
- Signed overflow 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 by natural wrap; no special case.
- flush:
  - Any state goes to IDLE on the next edge; stall is forced low in the flush cycle.
  - result_valid is 0 in the flush cycle and after; no result is produced.
  - en_in together with flush in IDLE is ignored.
- result and rd_out hold their last value outside DONE; consumers must qualify with result_valid.
- Back-to-back: a new divide can start in the first IDLE cycle after DONE (c36), so the minimum spacing is 36 cycles.
- Reset asserted mid-operation: immediate return to IDLE with outputs at reset values.

Test Plan:
- Unsigned 100 / 7, op_mod = 0, rd_in = 5 -> stall high c0..c34; at c35 result = 14, result_valid = 1, rd_out = 5; c36 stall 0.
- Signed mod: src_a = 0xFFFFFFF9 (-7), src_b = 2, op_mod = 1 -> result 0xFFFFFFFF (-1). Same operands with op_mod = 0 -> 0xFFFFFFFD (-3).
- Divide by zero: src_a = 0x1234, src_b = 0 -> DONE at c2 with quotient 0xFFFFFFFF; with op_mod = 1 -> 0x1234.
- Overflow: signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, at c35.
- Flush at c10 -> stall 0 in c10, IDLE at c11, result_valid never asserted. A new divide started at c11 completes at c46 with correct values.
- rstn pulsed low at c20 -> stall and result_valid 0 immediately; the next en_in starts a fresh 35-cycle divide.
